// File: rtl/retire_buffer_pkg.sv
// Shared types and sizing for the tag-indexed retire buffer.
package retire_buffer_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned N_XU  = 4;
    localparam int unsigned DEPTH = 2 ** TAG_W;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = TAG_W + 1;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] regD;
        logic [WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/retire_buffer_if.sv
// Issue, result and writeback signals between RLL/execution units and the retire buffer.
interface retire_buffer_if;
    import retire_buffer_pkg::*;

    logic                    issue_valid;
    logic [TAG_W-1:0]        issue_tag;
    logic [REG_W-1:0]        issue_regD;
    logic                    issue_ready;
    logic [N_XU-1:0]         res_valid;
    logic [N_XU*TAG_W-1:0]   res_tag;
    logic [N_XU*WIDTH-1:0]   res_data;
    logic                    wb_we;
    logic [REG_W-1:0]        wb_reg;
    logic [WIDTH-1:0]        wb_data;
    logic [TAG_W-1:0]        wb_tag;
    logic                    err;

    modport master (
        output issue_valid, issue_tag, issue_regD, res_valid, res_tag, res_data,
        input  issue_ready, wb_we, wb_reg, wb_data, wb_tag, err
    );

    modport slave (
        input  issue_valid, issue_tag, issue_regD, res_valid, res_tag, res_data,
        output issue_ready, wb_we, wb_reg, wb_data, wb_tag, err
    );

endinterface

// File: rtl/retire_buffer_arb.sv
// Fixed-priority resolver for result ports that name the same tag in one cycle.
module retire_arb
    import retire_buffer_pkg::*;
(
    input  logic [N_XU-1:0]       valid,
    input  logic [N_XU*TAG_W-1:0] tag,
    output logic [N_XU-1:0]       grant_c,
    output logic                  collision_c
);

    // A port loses whenever any lower-indexed valid port carries the same tag.
    always_comb begin
        grant_c     = '0;
        collision_c = 1'b0;
        for (int unsigned k = 0; k < N_XU; k++) begin
            grant_c[k] = valid[k];
            for (int unsigned j = 0; j < k; j++) begin
                if (valid[j] && (tag[j*TAG_W +: TAG_W] == tag[k*TAG_W +: TAG_W])) begin
                    grant_c[k] = 1'b0;
                end
            end
            if (valid[k] && !grant_c[k]) begin
                collision_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_buffer.sv
// Reorder/retire buffer: records issued destinations by tag, collects out-of-order
// results and retires in tag order onto the RLL regbank write port.
module retire_buffer
    import retire_buffer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    retire_buffer_if.slave  bus
);

    rob_entry_t       entries     [DEPTH];
    rob_entry_t       entries_nxt [DEPTH];
    rob_entry_t       head_entry;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] res_tag_k;
    logic [N_XU-1:0]  grant_c;
    logic             collision_c;
    logic             do_issue;
    logic             do_retire;
    logic             err_c;

    retire_arb u_arb (
        .valid       (bus.res_valid),
        .tag         (bus.res_tag),
        .grant_c     (grant_c),
        .collision_c (collision_c)
    );

    assign bus.issue_ready = (count != CNT_W'(DEPTH));

    // Next entry contents plus this cycle's protocol violations.
    always_comb begin
        entries_nxt = entries;
        err_c       = 1'b0;
        res_tag_k   = '0;
        head_entry  = entries[head];
        do_retire   = head_entry.valid && head_entry.done;
        do_issue    = bus.issue_valid && bus.issue_ready;

        if (bus.issue_valid && !bus.issue_ready) err_c = 1'b1;
        if (do_issue && (bus.issue_tag != tail)) err_c = 1'b1;
        if (collision_c)                         err_c = 1'b1;

        for (int unsigned k = 0; k < N_XU; k++) begin
            if (grant_c[k]) begin
                res_tag_k = bus.res_tag[k*TAG_W +: TAG_W];
                if (entries[res_tag_k].valid && !entries[res_tag_k].done) begin
                    entries_nxt[res_tag_k].done = 1'b1;
                    entries_nxt[res_tag_k].data = bus.res_data[k*WIDTH +: WIDTH];
                end else begin
                    err_c = 1'b1;
                end
            end
        end

        if (do_retire) entries_nxt[head].valid = 1'b0;

        // Tail slot is never the retiring head: a free tail means the head is empty or elsewhere.
        if (do_issue) begin
            entries_nxt[tail].valid = 1'b1;
            entries_nxt[tail].done  = 1'b0;
            entries_nxt[tail].regD  = bus.issue_regD;
            entries_nxt[tail].data  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            bus.wb_we   <= 1'b0;
            bus.wb_reg  <= '0;
            bus.wb_data <= '0;
            bus.wb_tag  <= '0;
            bus.err     <= 1'b0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
            tail      <= head;
            count     <= '0;
            bus.wb_we <= 1'b0;
        end else begin
            entries <= entries_nxt;
            count   <= count + CNT_W'(do_issue) - CNT_W'(do_retire);
            bus.err <= bus.err | err_c;
            if (do_issue) tail <= tail + TAG_W'(1);
            if (do_retire) begin
                head        <= head + TAG_W'(1);
                bus.wb_we   <= (head_entry.regD != '0);
                bus.wb_reg  <= head_entry.regD;
                bus.wb_data <= head_entry.data;
                bus.wb_tag  <= head;
            end else begin
                bus.wb_we <= 1'b0;
            end
        end
    end

endmodule
